// File: rtl/m68k_dma_bus_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// m68k_dma_bus_arbiter
//
// Shares the 68010 bus between the CPU and NREQ on-board DMA masters.
// Toward the CPU it runs the BR/BG/BGACK three-wire arbitration protocol.
// Among the DMA masters it picks one round-robin and hands it the bus with
// a one-hot grant. The bus goes back to the CPU when the owner drops its
// request or its tenure limit expires.
//
// Handshake (req/gnt): req[i] is a level request. gnt[i] rises only after
// req[i] was high on the acknowledge edge. Once granted, gnt[i] stays high
// until req[i] is dropped (the only voluntary release) or the tenure expires.
// A release is always followed by exactly one REL cycle in which neither BR
// nor BGACK is driven, so the CPU can re-own the bus before the next round.
//
// Ports
//   C100          in   system clock, all state changes on posedge
//   RESET_n       in   asynchronous active-low reset
//   req[NREQ]     in   level request per DMA master (synchronous to C100)
//   gnt[NREQ]     out  one-hot grant, at most one bit set
//   P_BG_n        in   bus grant from CPU (asynchronous, synchronised here)
//   P_AS_n        in   address strobe (asynchronous, synchronised here)
//   P_DTACK_n     in   data acknowledge (asynchronous, synchronised here)
//   P_BGACK_in_n  in   BGACK from other external masters (synchronised here)
//   P_BR_n        out  bus request to CPU, active low
//   P_BGACK_n     out  bus grant acknowledge, active low
//   busy          out  arbiter not in IDLE
//   tmo_err       out  one-cycle pulse: BG wait timed out or tenure expired
//   dbg_state     out  FSM state: 0 IDLE, 1 REQ, 2 OWN, 3 REL
// ---------------------------------------------------------------------------
module m68k_dma_bus_arbiter #(
    parameter int NREQ   = 2,
    parameter int BG_TMO = 255,
    parameter int TENURE = 64
) (
    input  logic            C100,
    input  logic            RESET_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    input  logic            P_BG_n,
    input  logic            P_AS_n,
    input  logic            P_DTACK_n,
    input  logic            P_BGACK_in_n,
    output logic            P_BR_n,
    output logic            P_BGACK_n,
    output logic            busy,
    output logic            tmo_err,
    output logic [1:0]      dbg_state
);

    localparam int          PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] BG_TMO_LD = 16'(BG_TMO);
    localparam logic [15:0] TENURE_LD = 16'(TENURE);

    // The acknowledge step (BGACK low, BR high, winner latched) happens on
    // the edge that leaves REQ, so it needs no state of its own.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_OWN  = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      sync1_q, sync2_q;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     ten_q, ten_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            br_n_q, br_n_d;
    logic            bgack_n_q, bgack_n_d;
    logic            busy_q, busy_d;
    logic            tmo_q, tmo_d;

    logic            bg_s, as_s, dtack_s, bgack_in_s;
    logic            grant_ok;
    logic            req_held;
    logic            ten_expire;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW:0]     cand;
    logic [PW:0]     rr_next_w;
    logic [PW-1:0]   rr_next;
    logic [NREQ-1:0] win_onehot;

    // Synchronised bus inputs, packed {BG, AS, DTACK, BGACK_in}.
    assign bg_s       = sync2_q[3];
    assign as_s       = sync2_q[2];
    assign dtack_s    = sync2_q[1];
    assign bgack_in_s = sync2_q[0];

    // Bus is ours only when the CPU granted it and the previous cycle has
    // fully finished (no AS, no DTACK) and no other master holds BGACK.
    assign grant_ok   = !bg_s && as_s && dtack_s && bgack_in_s;
    assign req_held   = |(req & gnt_q);
    // ten_q counts the remaining OWN cycles; expiry is the cycle in which
    // it would reach 0, giving exactly TENURE cycles of grant.
    assign ten_expire = (TENURE != 0) && (ten_q <= 16'd1);

    // Round-robin pick: first set req bit at or after rr_q, wrapping.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin : pick_winner
        win_found  = 1'b0;
        win_idx    = '0;
        cand       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (req[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
        rr_next_w = {1'b0, win_idx} + (PW+1)'(1);
        if (rr_next_w >= (PW+1)'(NREQ)) begin
            rr_next_w = '0;
        end
        rr_next    = rr_next_w[PW-1:0];
        win_onehot = '0;
        win_onehot[win_idx] = 1'b1;
    end

    // State register and all registered outputs.
    always_ff @(posedge C100 or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= ST_IDLE;
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            cnt_q     <= '0;
            ten_q     <= '0;
            rr_q      <= '0;
            gnt_q     <= '0;
            br_n_q    <= 1'b1;
            bgack_n_q <= 1'b1;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= {P_BG_n, P_AS_n, P_DTACK_n, P_BGACK_in_n};
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            ten_q     <= ten_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            br_n_q    <= br_n_d;
            bgack_n_q <= bgack_n_d;
            busy_q    <= busy_d;
            tmo_q     <= tmo_d;
        end
    end

    // Next-state logic. In REQ a grant beats both a request drop and a
    // timeout that land on the same cycle.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (grant_ok) begin
                    state_d = win_found ? ST_OWN : ST_REL;
                end else if (!(|req) || (cnt_q == '0)) begin
                    state_d = ST_REL;
                end
            end
            ST_OWN: begin
                if (!req_held || ten_expire) state_d = ST_REL;
            end
            ST_REL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of counters and registered outputs.
    always_comb begin : output_next
        cnt_d     = cnt_q;
        ten_d     = ten_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        br_n_d    = br_n_q;
        bgack_n_d = bgack_n_q;
        tmo_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    br_n_d = 1'b0;
                    cnt_d  = BG_TMO_LD;
                end
            end
            ST_REQ: begin
                if (grant_ok) begin
                    br_n_d = 1'b1;
                    if (win_found) begin
                        bgack_n_d = 1'b0;
                        gnt_d     = win_onehot;
                        rr_d      = rr_next;
                        ten_d     = TENURE_LD;
                    end
                end else if (!(|req)) begin
                    br_n_d = 1'b1;
                end else if (cnt_q == '0) begin
                    br_n_d = 1'b1;
                    tmo_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_OWN: begin
                if (ten_q != '0) ten_d = ten_q - 16'd1;
                // A drop coinciding with expiry is an ordinary release.
                if (!req_held) begin
                    gnt_d     = '0;
                    bgack_n_d = 1'b1;
                end else if (ten_expire) begin
                    gnt_d     = '0;
                    bgack_n_d = 1'b1;
                    tmo_d     = 1'b1;
                end
            end
            default: begin
                gnt_d     = '0;
                br_n_d    = 1'b1;
                bgack_n_d = 1'b1;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign gnt       = gnt_q;
    assign P_BR_n    = br_n_q;
    assign P_BGACK_n = bgack_n_q;
    assign busy      = busy_q;
    assign tmo_err   = tmo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_m68k_dma_bus_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for m68k_dma_bus_arbiter (NREQ=2, BG_TMO=8, TENURE=16).
module tb_m68k_dma_bus_arbiter;

    localparam int NREQ   = 2;
    localparam int BG_TMO = 8;
    localparam int TENURE = 16;

    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_OWN  = 2;
    localparam int PH_REL  = 3;

    // ---------------- clock / reset / DUT ----------------
    logic            clk     = 1'b0;
    logic            RESET_n = 1'b0;
    logic [NREQ-1:0] req     = '0;
    logic            bg_n    = 1'b1;
    logic            as_n    = 1'b1;
    logic            dtack_n = 1'b1;
    logic            bgin_n  = 1'b1;
    logic [NREQ-1:0] gnt;
    logic            P_BR_n, P_BGACK_n, busy, tmo_err;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    m68k_dma_bus_arbiter #(
        .NREQ   (NREQ),
        .BG_TMO (BG_TMO),
        .TENURE (TENURE)
    ) dut (
        .C100         (clk),
        .RESET_n      (RESET_n),
        .req          (req),
        .gnt          (gnt),
        .P_BG_n       (bg_n),
        .P_AS_n       (as_n),
        .P_DTACK_n    (dtack_n),
        .P_BGACK_in_n (bgin_n),
        .P_BR_n       (P_BR_n),
        .P_BGACK_n    (P_BGACK_n),
        .busy         (busy),
        .tmo_err      (tmo_err),
        .dbg_state    (dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RESET_n = 1'b0;
        req     = '0;
        bg_n    = 1'b1;
        as_n    = 1'b1;
        dtack_n = 1'b1;
        bgin_n  = 1'b1;
        repeat (3) tick();
        RESET_n = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] dut_out();
        return {gnt, P_BR_n, P_BGACK_n, busy, tmo_err};
    endfunction

    function automatic logic cur(input int which);
        case (which)
            0:       return |gnt;
            1:       return P_BR_n;
            2:       return P_BGACK_n;
            3:       return tmo_err;
            default: return busy;
        endcase
    endfunction

    // Tick until the selected signal takes val, at most budget cycles.
    task automatic wait_for(input string name, input int which, input logic val,
                            input int budget, output int n);
        n = 0;
        while (cur(which) !== val && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(cur(which)), 32'(val));
    endtask

    // ---------------- reference model ----------------
    int              m_phase;
    int              m_rr;
    int              m_win;
    int              m_waited;
    int              m_owned;
    logic [3:0]      m_sync_q[$];
    logic [NREQ-1:0] e_gnt;
    logic            e_br_n, e_bgack_n, e_busy, e_tmo;

    task automatic model_reset();
        m_phase   = PH_IDLE;
        m_rr      = 0;
        m_win     = 0;
        m_waited  = 0;
        m_owned   = 0;
        m_sync_q  = {4'hF, 4'hF};
        e_gnt     = '0;
        e_br_n    = 1'b1;
        e_bgack_n = 1'b1;
        e_busy    = 1'b0;
        e_tmo     = 1'b0;
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return 0;
    endfunction

    // One rising edge: r and raw = {bg, as, dtack, bgin} are the values
    // present at that edge; bus inputs reach the decision two edges later.
    task automatic model_step(input logic [NREQ-1:0] r, input logic [3:0] raw);
        logic [3:0] s;
        s = m_sync_q.pop_front();
        m_sync_q.push_back(raw);
        e_tmo = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                if (r != 0) begin
                    m_phase  = PH_WAIT;
                    m_waited = 0;
                    e_br_n   = 1'b0;
                end
            end
            PH_WAIT: begin
                if (s == 4'b0111) begin
                    e_br_n = 1'b1;
                    if (r != 0) begin
                        m_win     = pick(r, m_rr);
                        m_rr      = (m_win + 1) % NREQ;
                        e_gnt     = '0;
                        e_gnt[m_win] = 1'b1;
                        e_bgack_n = 1'b0;
                        m_owned   = 0;
                        m_phase   = PH_OWN;
                    end else begin
                        m_phase = PH_REL;
                    end
                end else if (r == 0) begin
                    e_br_n  = 1'b1;
                    m_phase = PH_REL;
                end else if (m_waited == BG_TMO) begin
                    e_br_n  = 1'b1;
                    e_tmo   = 1'b1;
                    m_phase = PH_REL;
                end else begin
                    m_waited++;
                end
            end
            PH_OWN: begin
                m_owned++;
                if (!r[m_win]) begin
                    e_gnt     = '0;
                    e_bgack_n = 1'b1;
                    m_phase   = PH_REL;
                end else if (TENURE != 0 && m_owned == TENURE) begin
                    e_gnt     = '0;
                    e_bgack_n = 1'b1;
                    e_tmo     = 1'b1;
                    m_phase   = PH_REL;
                end
            end
            default: begin
                m_phase = PH_IDLE;
            end
        endcase
        e_busy = (m_phase != PH_IDLE);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] req;
        logic       bg_n;
        logic       as_n;
        logic [1:0] gnt;
        logic       br_n;
        logic       bgack_n;
        logic       busy;
        logic       tmo;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int n;
        int bad;
        logic [1:0] exp_rr[4];

        // Inputs apply before an edge; expectations are the outputs after it.
        vecs[0]  = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{2'b01, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{2'b11, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Reset state.
        do_reset();
        check("reset_outputs", 32'(dut_out()), 32'({2'b00, 1'b1, 1'b1, 1'b0, 1'b0}));
        check("reset_state_idle", 32'(dbg_state), 32'd0);

        // Basic grant latency and round-robin through the table.
        for (int i = 0; i < 17; i++) begin
            req  = vecs[i].req;
            bg_n = vecs[i].bg_n;
            as_n = vecs[i].as_n;
            tick();
            check($sformatf("vec%0d", i), 32'(dut_out()),
                  32'({vecs[i].gnt, vecs[i].br_n, vecs[i].bgack_n, vecs[i].busy, vecs[i].tmo}));
        end

        // Four rounds with both requesting: grants alternate.
        do_reset();
        bg_n = 1'b0;
        req  = 2'b11;
        for (int r = 0; r < 4; r++) begin
            wait_for($sformatf("rr_round%0d_wait", r), 0, 1'b1, 40, n);
            check($sformatf("rr_round%0d_gnt", r), 32'(gnt), 32'(exp_rr[r]));
            req = 2'b00;
            tick();
            check($sformatf("rr_round%0d_release", r), 32'({gnt, P_BGACK_n}), 32'({2'b00, 1'b1}));
            req = 2'b11;
        end

        // AS held low: never acknowledge while the bus is still busy.
        do_reset();
        bg_n = 1'b0;
        as_n = 1'b0;
        req  = 2'b01;
        bad  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (P_BGACK_n !== 1'b1 || gnt !== 2'b00) bad++;
        end
        check("no_bgack_while_as_low", 32'(bad), 32'd0);
        // AS rises after 5 cycles: BGACK three edges later.
        do_reset();
        bg_n = 1'b0;
        as_n = 1'b0;
        req  = 2'b01;
        repeat (5) tick();
        as_n = 1'b1;
        wait_for("as_rise_bgack_wait", 2, 1'b0, 10, n);
        check("as_rise_to_bgack_cycles", 32'(n), 32'd3);

        // BG never asserted: timeout pulse 9 edges after BR low.
        do_reset();
        req = 2'b01;
        wait_for("tmo_br_low_wait", 1, 1'b0, 5, n);
        wait_for("tmo_pulse_wait", 3, 1'b1, 20, n);
        check("bg_timeout_cycles", 32'(n), 32'd9);
        check("bg_timeout_release", 32'({gnt, P_BR_n, P_BGACK_n, busy}), 32'({2'b00, 1'b1, 1'b1, 1'b1}));
        tick();
        check("bg_timeout_pulse_end", 32'({tmo_err, busy}), 32'({1'b0, 1'b0}));
        req = 2'b00;

        // Grant conditions become true on the timeout cycle: grant wins.
        do_reset();
        req = 2'b01;
        wait_for("race_br_low_wait", 1, 1'b0, 5, n);
        repeat (6) tick();
        bg_n = 1'b0;
        tick();
        tick();
        check("race_no_gnt_yet", 32'(gnt), 32'd0);
        tick();
        check("race_grant_wins", 32'({gnt, tmo_err, P_BGACK_n}), 32'({2'b01, 1'b0, 1'b0}));

        // Tenure limit: 16 cycles of grant, tmo pulse, new round 2 later.
        do_reset();
        bg_n = 1'b0;
        req  = 2'b01;
        wait_for("tenure_gnt_wait", 0, 1'b1, 20, n);
        n = 0;
        while (gnt != 2'b00 && n < 40) begin
            tick();
            n++;
        end
        check("tenure_cycles", 32'(n), 32'd16);
        check("tenure_tmo_pulse", 32'({tmo_err, P_BGACK_n}), 32'({1'b1, 1'b1}));
        wait_for("tenure_retry_wait", 1, 1'b0, 10, n);
        check("tenure_retry_cycles", 32'(n), 32'd2);

        // Drop on the expiry cycle: ordinary release, no tmo.
        do_reset();
        bg_n = 1'b0;
        req  = 2'b01;
        wait_for("drop_exp_gnt_wait", 0, 1'b1, 20, n);
        repeat (15) tick();
        check("drop_exp_still_owned", 32'(gnt), 32'(2'b01));
        req = 2'b00;
        tick();
        check("drop_exp_no_tmo", 32'({gnt, tmo_err}), 32'({2'b00, 1'b0}));

        // Asynchronous reset while owning the bus.
        do_reset();
        bg_n = 1'b0;
        req  = 2'b01;
        wait_for("areset_gnt_wait", 0, 1'b1, 20, n);
        #3;
        RESET_n = 1'b0;
        #1;
        check("areset_outputs", 32'(dut_out()), 32'({2'b00, 1'b1, 1'b1, 1'b0, 1'b0}));
        req = 2'b00;
        tick();
        RESET_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy !== 1'b0 || P_BR_n !== 1'b1) bad++;
        end
        check("areset_stays_idle", 32'(bad), 32'd0);

        // Randomised traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            check("rand_outputs", 32'(dut_out()), 32'({e_gnt, e_br_n, e_bgack_n, e_busy, e_tmo}));
            if ($urandom_range(0, 7) == 0) req[$urandom_range(0, NREQ-1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) bg_n    = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 3) == 0) as_n    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) dtack_n = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) bgin_n  = ($urandom_range(0, 9) != 0);
            model_step(req, {bg_n, as_n, dtack_n, bgin_n});
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
